// File: rtl/prefix_accumulator_pkg.sv
// Shared decode-stage definitions: prefix byte encodings, segment IDs,
// accumulator state encoding and descriptor field widths.
package prefix_accumulator_pkg;

    localparam int BYTE_W = 8;
    localparam int SEG_W  = 3;

    localparam logic [BYTE_W-1:0] PFX_REP  = 8'hF2;
    localparam logic [BYTE_W-1:0] PFX_OPSZ = 8'h66;
    localparam logic [BYTE_W-1:0] PFX_ES   = 8'h26;
    localparam logic [BYTE_W-1:0] PFX_CS   = 8'h2E;
    localparam logic [BYTE_W-1:0] PFX_SS   = 8'h36;
    localparam logic [BYTE_W-1:0] PFX_DS   = 8'h3E;
    localparam logic [BYTE_W-1:0] PFX_FS   = 8'h64;
    localparam logic [BYTE_W-1:0] PFX_GS   = 8'h65;

    localparam logic [SEG_W-1:0] SEG_ES = 3'd0;
    localparam logic [SEG_W-1:0] SEG_CS = 3'd1;
    localparam logic [SEG_W-1:0] SEG_SS = 3'd2;
    localparam logic [SEG_W-1:0] SEG_DS = 3'd3;
    localparam logic [SEG_W-1:0] SEG_FS = 3'd4;
    localparam logic [SEG_W-1:0] SEG_GS = 3'd5;

    typedef enum logic {
        S_NOPFX = 1'b0,
        S_PFX   = 1'b1
    } state_t;

    typedef struct packed {
        logic             op_override;
        logic             seg_override;
        logic [SEG_W-1:0] seg_id;
        logic             rep;
    } pfx_flags_t;

endpackage

// File: rtl/prefix_accumulator_if.sv
// Byte-in / descriptor-out handshake bundle for decode stage 0.
interface prefix_accumulator_if #(
    parameter int CNT_W = 3
);
    import prefix_accumulator_pkg::*;

    logic              flush;
    logic              in_valid;
    logic [BYTE_W-1:0] in_byte;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_opcode;
    logic              out_op_override;
    logic              out_seg_override;
    logic [SEG_W-1:0]  out_segID;
    logic              out_repeat;
    logic [CNT_W-1:0]  out_prefix_cnt;
    logic              out_error;

    // Fetch queue and opcode decoder side.
    modport master (
        output flush, in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_opcode, out_op_override, out_seg_override,
               out_segID, out_repeat, out_prefix_cnt, out_error
    );

    // Accumulator side.
    modport slave (
        input  flush, in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_opcode, out_op_override, out_seg_override,
               out_segID, out_repeat, out_prefix_cnt, out_error
    );

endinterface

// File: rtl/prefix_accumulator_prefix_checker.sv
// Combinational classifier: decides whether a byte is a legacy prefix and
// which prefix flags it contributes.
module prefix_checker
    import prefix_accumulator_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic              is_prefix,
    output logic              is_opcode,
    output logic              op_override,
    output logic              seg_override,
    output logic [SEG_W-1:0]  seg_id,
    output logic              rep
);

    always_comb begin
        is_prefix    = 1'b1;
        op_override  = 1'b0;
        seg_override = 1'b0;
        seg_id       = SEG_ES;
        rep          = 1'b0;
        case (data)
            PFX_REP:  rep         = 1'b1;
            PFX_OPSZ: op_override = 1'b1;
            PFX_ES:   begin seg_override = 1'b1; seg_id = SEG_ES; end
            PFX_CS:   begin seg_override = 1'b1; seg_id = SEG_CS; end
            PFX_SS:   begin seg_override = 1'b1; seg_id = SEG_SS; end
            PFX_DS:   begin seg_override = 1'b1; seg_id = SEG_DS; end
            PFX_FS:   begin seg_override = 1'b1; seg_id = SEG_FS; end
            PFX_GS:   begin seg_override = 1'b1; seg_id = SEG_GS; end
            default:  is_prefix   = 1'b0;
        endcase
    end

    assign is_opcode = !is_prefix;

endmodule

// File: rtl/prefix_accumulator.sv
// Decode stage 0: folds prefix bytes into a summary and emits one registered
// descriptor per instruction when the opcode byte (or a prefix overflow) arrives.
module prefix_accumulator
    import prefix_accumulator_pkg::*;
#(
    parameter int MAX_PREFIX = 4,
    parameter int CNT_W      = 3
)(
    input logic                 clk,
    input logic                 reset,
    prefix_accumulator_if.slave bus
);

    state_t           state, state_nxt;
    pfx_flags_t       acc;
    logic [CNT_W-1:0] cnt;

    logic             chk_is_prefix, chk_is_opcode;
    logic             chk_op_override, chk_seg_override, chk_rep;
    logic [SEG_W-1:0] chk_seg_id;

    logic accept, at_limit, take_pfx, emit_op, emit_err, emit;

    prefix_checker u_checker (
        .data         (bus.in_byte),
        .is_prefix    (chk_is_prefix),
        .is_opcode    (chk_is_opcode),
        .op_override  (chk_op_override),
        .seg_override (chk_seg_override),
        .seg_id       (chk_seg_id),
        .rep          (chk_rep)
    );

    // A held descriptor blocks every byte, prefixes included, so the
    // accumulator never runs ahead of a stalled decoder.
    assign bus.in_ready = !reset && !bus.flush && (!bus.out_valid || bus.out_ready);

    assign accept   = bus.in_valid && bus.in_ready;
    assign at_limit = (cnt == CNT_W'(MAX_PREFIX));
    assign take_pfx = accept && chk_is_prefix && !at_limit;
    assign emit_op  = accept && chk_is_opcode;
    assign emit_err = accept && chk_is_prefix && at_limit;
    assign emit     = emit_op || emit_err;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) state <= S_NOPFX;
        else                    state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_NOPFX: if (take_pfx) state_nxt = S_PFX;
            S_PFX:   if (emit)     state_nxt = S_NOPFX;
            default:               state_nxt = S_NOPFX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (take_pfx) begin
            cnt             <= cnt + CNT_W'(1);
            acc.op_override <= acc.op_override | chk_op_override;
            acc.rep         <= acc.rep | chk_rep;
            // Last segment prefix wins.
            if (chk_seg_override) begin
                acc.seg_override <= 1'b1;
                acc.seg_id       <= chk_seg_id;
            end
        end else if (emit) begin
            acc <= '0;
            cnt <= '0;
        end
    end

    // The overflowing prefix is reported as the opcode; its own flags are
    // not folded in, so the descriptor reflects the prefixes that fit.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            bus.out_valid        <= 1'b0;
            bus.out_opcode       <= '0;
            bus.out_op_override  <= 1'b0;
            bus.out_seg_override <= 1'b0;
            bus.out_segID        <= '0;
            bus.out_repeat       <= 1'b0;
            bus.out_prefix_cnt   <= '0;
            bus.out_error        <= 1'b0;
        end else if (emit) begin
            bus.out_valid        <= 1'b1;
            bus.out_opcode       <= bus.in_byte;
            bus.out_op_override  <= acc.op_override;
            bus.out_seg_override <= acc.seg_override;
            bus.out_segID        <= acc.seg_id;
            bus.out_repeat       <= acc.rep;
            bus.out_prefix_cnt   <= cnt;
            bus.out_error        <= emit_err;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prefix_accumulator.sv
// Directed bench for prefix_accumulator: each task drives one scenario and
// compares the full descriptor against hand-computed values.
module tb_prefix_accumulator;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    prefix_accumulator_if #(.CNT_W(3)) bus();

    prefix_accumulator #(.MAX_PREFIX(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {valid, opcode, op_override, seg_override, segID, repeat, cnt, error}
    typedef logic [18:0] desc_t;

    function automatic desc_t desc();
        return {bus.out_valid, bus.out_opcode, bus.out_op_override, bus.out_seg_override,
                bus.out_segID, bus.out_repeat, bus.out_prefix_cnt, bus.out_error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        desc_t exp;
        reset = 1'b1; bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_byte = 8'h89;
        tick(); tick();
        exp = '0;
        checks++;
        if (desc() !== exp) $display("FAIL reset_desc got=%h want=%h", desc(), exp);
        else passes++;
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
        else passes++;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        desc_t exp;
        send(8'h66);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_no_out_66 got=%b want=0", bus.out_valid);
        else passes++;
        send(8'h2E);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_no_out_2e got=%b want=0", bus.out_valid);
        else passes++;
        send(8'h89);
        exp = {1'b1, 8'h89, 1'b1, 1'b1, 3'd1, 1'b0, 3'd2, 1'b0};
        checks++;
        if (desc() !== exp) $display("FAIL basic_desc got=%h want=%h", desc(), exp);
        else passes++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_consumed got=%b want=0", bus.out_valid);
        else passes++;
    endtask

    task automatic test_back_to_back();
        desc_t exp;
        send(8'hF2);
        send(8'hA4);
        exp = {1'b1, 8'hA4, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0};
        checks++;
        if (desc() !== exp) $display("FAIL b2b_a4 got=%h want=%h", desc(), exp);
        else passes++;
        send(8'h90);
        exp = {1'b1, 8'h90, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
        checks++;
        if (desc() !== exp) $display("FAIL b2b_90 got=%h want=%h", desc(), exp);
        else passes++;
        tick();
    endtask

    task automatic test_limit();
        desc_t exp;
        send(8'h26); send(8'h36); send(8'h64); send(8'h65);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL limit_no_early_out got=%b want=0", bus.out_valid);
        else passes++;
        send(8'h3E);
        exp = {1'b1, 8'h3E, 1'b0, 1'b1, 3'd5, 1'b0, 3'd4, 1'b1};
        checks++;
        if (desc() !== exp) $display("FAIL limit_err_desc got=%h want=%h", desc(), exp);
        else passes++;
        send(8'h90);
        exp = {1'b1, 8'h90, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
        checks++;
        if (desc() !== exp) $display("FAIL limit_clean_after got=%h want=%h", desc(), exp);
        else passes++;
        tick();
    endtask

    task automatic test_backpressure();
        desc_t exp;
        bus.out_ready = 1'b0;
        send(8'hC3);
        exp = {1'b1, 8'hC3, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
        bus.in_valid = 1'b1; bus.in_byte = 8'h8B;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_low got=%b want=0", bus.in_ready);
        else passes++;
        tick();
        checks++;
        if (desc() !== exp) $display("FAIL bp_held got=%h want=%h", desc(), exp);
        else passes++;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_high got=%b want=1", bus.in_ready);
        else passes++;
        tick();
        bus.in_valid = 1'b0;
        exp = {1'b1, 8'h8B, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
        checks++;
        if (desc() !== exp) $display("FAIL bp_reload got=%h want=%h", desc(), exp);
        else passes++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got=%b want=0", bus.out_valid);
        else passes++;
    endtask

    task automatic test_flush();
        desc_t exp;
        send(8'h66);
        send(8'h65);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_byte = 8'h8B;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b want=0", bus.in_ready);
        else passes++;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        exp = '0;
        checks++;
        if (desc() !== exp) $display("FAIL flush_cleared got=%h want=%h", desc(), exp);
        else passes++;
        send(8'h8B);
        exp = {1'b1, 8'h8B, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
        checks++;
        if (desc() !== exp) $display("FAIL flush_next_desc got=%h want=%h", desc(), exp);
        else passes++;
        tick();
    endtask

    task automatic test_mid_reset();
        desc_t exp;
        send(8'h2E);
        reset = 1'b1;
        tick();
        exp = '0;
        checks++;
        if (desc() !== exp) $display("FAIL mreset_desc got=%h want=%h", desc(), exp);
        else passes++;
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL mreset_in_ready got=%b want=0", bus.in_ready);
        else passes++;
        reset = 1'b0;
        send(8'hC3);
        exp = {1'b1, 8'hC3, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
        checks++;
        if (desc() !== exp) $display("FAIL mreset_c3 got=%h want=%h", desc(), exp);
        else passes++;
        tick();
    endtask

    task automatic test_idle_hold();
        desc_t exp;
        send(8'h66);
        tick(); tick(); tick();
        send(8'h66);
        send(8'h90);
        exp = {1'b1, 8'h90, 1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0};
        checks++;
        if (desc() !== exp) $display("FAIL idle_dup_desc got=%h want=%h", desc(), exp);
        else passes++;
        tick();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.flush = 1'b0; bus.out_ready = 1'b1;
        reset = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_limit();
        test_backpressure();
        test_flush();
        test_mid_reset();
        test_idle_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
